mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for mult/multu/madd/maddu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for div/divu.
REQ-003 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1 bit, qualifies MDUOp for one cycle.
REQ-006 SHALL have port MDUOp, input, 3 bits, operation code.
  - Codes: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd/maddu.
REQ-007 SHALL have port MaddU, input, 1 bit, selecting unsigned for code 7.
REQ-008 SHALL have port A, input, 32 bits, the rs operand taken from the register file RD1.
REQ-009 SHALL have port B, input, 32 bits, the rt operand taken from the register file RD2.
REQ-010 SHALL have port Busy, output, 1 bit, high while an operation is in flight.
REQ-011 SHALL have port HI, output, 32 bits, the architectural HI register.
REQ-012 SHALL have port LO, output, 32 bits, the architectural LO register.

Function
REQ-013 SHALL accept a request when Start=1 and Busy=0 at a rising edge; Start while Busy=1 SHALL be ignored with no state change.
REQ-014 SHALL, on accepted mult/multu/madd/div/divu, latch A and B and load the cycle counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 SHALL drive Busy=(counter!=0) registered, so that Busy is high for exactly N cycles after the accept edge.
REQ-016 SHALL commit the result to HI/LO on the edge where the counter goes 1->0; HI/LO SHALL hold their old values while Busy=1.
REQ-017 SHALL apply mult/multu as {HI,LO} = A*B, a 64-bit signed or unsigned product.
REQ-018 SHALL apply div/divu as LO = quotient and HI = remainder, both truncated toward zero, with the remainder taking the dividend's sign.
REQ-019 SHALL, for a divide with B==0, still run DIV_CYCLES of Busy but leave HI/LO unchanged.
REQ-020 SHALL, for a signed divide of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-021 SHALL, for mthi/mtlo, write A into HI/LO on the accept edge with no Busy cycle.
REQ-022 SHALL treat MDUOp=0, and code 7 when the feature is compiled out, as a no-op even when Start=1.
REQ-023 SHALL treat operands as sampled only at accept; A/B changes during Busy SHALL have no effect.

Reset
REQ-024 SHALL, on Reset=0 at any time including mid-operation, immediately clear HI=0, LO=0, Busy=0, the counter and the latched operands, abandoning any in-flight result.
REQ-025 SHALL leave a request presented in the first edge after reset release accepted normally.

Configuration
REQ-026 SHALL, with MDU_MADD_EN defined, implement code 7 as {HI,LO} += A*B, signed or unsigned per MaddU, modulo 2^64, with MULT_CYCLES latency.
  - The add uses the HI/LO values at commit time.
REQ-027 SHALL, without MDU_MADD_EN, treat code 7 per REQ-022, and MaddU SHALL be unused.

Structure
REQ-028 SHALL take the MDUOp code constants and default cycle constants from shared package mdu_pkg.
REQ-029 SHALL be a single module with no sub-module, using the counter plus registered result.

Verification
REQ-030 SHALL cover: mult A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
REQ-032 SHALL cover: mthi A=0x12345678 -> HI=0x12345678 after 1 edge with Busy=0; Start mult during Busy -> ignored, and only the first result is committed.
REQ-033 SHALL cover: Reset=0 asserted on cycle 4 of a div -> Busy, HI and LO go to 0 immediately; no commit occurs after release.
REQ-034 SHALL cover, with MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0; without the macro the same stimulus leaves HI/LO unchanged and Busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcodes, default latencies and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_MADD  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit with a countdown busy timer.
// Define MDU_MADD_EN to enable opcode 7 (madd/maddu accumulate into {HI,LO}).
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic        MaddU,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_op_e          op_req;
    mdu_op_e          op_reg, op_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] num_mag, den_mag, quot_mag, rem_mag, quot, rem;

`ifdef MDU_MADD_EN
    logic        maddu_reg, maddu_next;
    logic [63:0] madd_sum;
`else
    logic        unused_maddu;
    assign unused_maddu = MaddU;
`endif

    assign op_req = mdu_op_e'(MDUOp);

    // Results are formed from the operands latched at accept, so A/B may change freely while busy.
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};
    assign prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};

    // Sign-magnitude divide: avoids the 0x80000000 / -1 overflow and keeps remainder on the dividend's sign.
    assign div_signed = (op_reg == MDU_DIV);
    assign num_mag    = div_signed ? abs32(a_reg) : a_reg;
    assign den_mag    = (b_reg == 32'd0) ? 32'd1 : (div_signed ? abs32(b_reg) : b_reg);
    assign quot_mag   = num_mag / den_mag;
    assign rem_mag    = num_mag % den_mag;
    assign quot       = (div_signed && (a_reg[31] ^ b_reg[31])) ? (32'd0 - quot_mag) : quot_mag;
    assign rem        = (div_signed && a_reg[31]) ? (32'd0 - rem_mag) : rem_mag;

`ifdef MDU_MADD_EN
    assign madd_sum = {hi_reg, lo_reg} + (maddu_reg ? prod_u : prod_s);
`endif

    always_comb begin
        op_next  = op_reg;
        a_next   = a_reg;
        b_next   = b_reg;
        hi_next  = hi_reg;
        lo_next  = lo_reg;
        cnt_next = cnt_reg;
`ifdef MDU_MADD_EN
        maddu_next = maddu_reg;
`endif
        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
                case (op_reg)
                    MDU_MULT:  {hi_next, lo_next} = prod_s;
                    MDU_MULTU: {hi_next, lo_next} = prod_u;
                    MDU_DIV, MDU_DIVU: begin
                        if (b_reg != 32'd0) begin
                            lo_next = quot;
                            hi_next = rem;
                        end
                    end
`ifdef MDU_MADD_EN
                    MDU_MADD:  {hi_next, lo_next} = madd_sum;
`endif
                    default: ;
                endcase
            end
        end else if (Start) begin
            case (op_req)
                MDU_MULT, MDU_MULTU: begin
                    op_next  = op_req;
                    a_next   = A;
                    b_next   = B;
                    cnt_next = MULT_LOAD;
                end
                MDU_DIV, MDU_DIVU: begin
                    op_next  = op_req;
                    a_next   = A;
                    b_next   = B;
                    cnt_next = DIV_LOAD;
                end
                MDU_MTHI: hi_next = A;
                MDU_MTLO: lo_next = A;
`ifdef MDU_MADD_EN
                MDU_MADD: begin
                    op_next    = op_req;
                    a_next     = A;
                    b_next     = B;
                    maddu_next = MaddU;
                    cnt_next   = MULT_LOAD;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_reg   <= MDU_NONE;
            a_reg    <= '0;
            b_reg    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
`ifdef MDU_MADD_EN
            maddu_reg <= 1'b0;
`endif
        end else begin
            op_reg   <= op_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            hi_reg   <= hi_next;
            lo_reg   <= lo_next;
            cnt_reg  <= cnt_next;
            busy_reg <= (cnt_next != '0);
`ifdef MDU_MADD_EN
            maddu_reg <= maddu_next;
`endif
        end
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule
